threshold_monitor: RTL and testbench
====================================

# threshold_monitor

- Streaming alarm stage placed directly downstream of the 4-bit magnitude comparator.
- Samples are compared against a high and a low threshold.
- Asserts a registered alarm after `PERSIST` consecutive samples exceed the high threshold.
- Deasserts after `PERSIST` consecutive samples fall below the low threshold, giving hysteresis.
- Turns raw greater/less/equal flags into a debounced, event-counted status for control logic.

## Interface
- `WIDTH`, 4: sample and threshold width.
- `PERSIST`, 3: consecutive qualifying samples needed to enter or leave alarm; legal range 1..15.
- `CNT_W`, 8: width of the saturating alarm-entry counter.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: the block has one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- `sample_valid` input 1: sample is accepted on a rising edge where this is 1.
- `sample` input `WIDTH`: unsigned sample.
- `thr_hi` input `WIDTH`: unsigned high threshold, strict compare `sample > thr_hi`.
- `thr_lo` input `WIDTH`: unsigned low threshold, strict compare `sample < thr_lo`.
- `clear` input 1: synchronous clear of state, persistence counter and `alarm_count`.
- `alarm` output 1: registered alarm level.
- `rise_pulse` output 1: one-cycle pulse on alarm entry.
- `fall_pulse` output 1: one-cycle pulse on alarm exit.
- `state` output 2: FSM state, encoded NORMAL=0, ARMING=1, ALARM=2, CLEARING=3.
- `alarm_count` output `CNT_W`: alarm entries, saturating at all-ones.

## Operation
- Two comparator instances produce `hi_gt` (sample vs `thr_hi`) and `lo_lt` (sample vs `thr_lo`).
- Internal persistence counter `pcnt` has width 4.

State transitions, evaluated only when `sample_valid`=1 and `clear`=0:
- **NORMAL:**
  - `hi_gt` with `PERSIST`=1 → ALARM.
  - `hi_gt` with `PERSIST`>1 → ARMING, `pcnt`=1.
  - Otherwise stay.
- **ARMING:**
  - `hi_gt` → `pcnt`+1; on reaching `PERSIST` → ALARM.
  - Not `hi_gt`, including equality → NORMAL, `pcnt`=0.
- **ALARM:** mirror of NORMAL using `lo_lt`; goes to CLEARING, or directly to NORMAL when `PERSIST`=1.
- **CLEARING:**
  - `lo_lt` → `pcnt`+1; on reaching `PERSIST` → NORMAL.
  - Not `lo_lt` → ALARM, `pcnt`=0.

Rules:
- `alarm` is 1 in ALARM and CLEARING, 0 otherwise.
- Every entry to ALARM from ARMING or NORMAL:
  - pulses `rise_pulse`;
  - increments `alarm_count`, which holds at max.
- Every exit to NORMAL from CLEARING or ALARM pulses `fall_pulse`.
- `sample_valid`=0: state, `pcnt` and all outputs hold; pulses drop to 0.
- `clear`=1 has priority over a simultaneous valid sample. Next state is NORMAL, `pcnt`=0, `alarm_count`=0.
  - If `alarm` was 1, clear does not pulse `fall_pulse`.
- `thr_lo` > `thr_hi` is legal. Entry uses only `hi_gt`, exit uses only `lo_lt`, with no special handling.

## Timing
- Reset values of all outputs:
  - `alarm`=0, `rise_pulse`=0, `fall_pulse`=0;
  - `state`=NORMAL, `alarm_count`=0;
  - internal `pcnt`=0.
- Reset asserted mid-sequence aborts immediately and asynchronously.
- All outputs are registered.
- Latency: `alarm` rises in the cycle after the edge that accepts the `PERSIST`-th consecutive qualifying sample. `rise_pulse` is high for exactly that cycle.
- Thresholds are sampled on the same edge as the sample. Changing a threshold mid-sequence affects only later samples.
- Back-to-back valid samples are accepted every cycle. There is no backpressure.

## Configuration
- `THRMON_STICKY_EN` defined:
  - ALARM ignores `lo_lt`; only `clear` or reset leave it;
  - CLEARING is unreachable;
  - `fall_pulse` is tied to 0.
- `THRMON_STICKY_EN` undefined: hysteresis exit as described above.

## Structure
- Package `thrmon_pkg` holds:
  - the state enum type `thrmon_state_t` (2 bits);
  - constant `THRMON_PCNT_W`=4.
- Sub-module: the existing `MagnitudeComparator`, instantiated twice for the threshold compares.
  - Both instances are purely combinational.
  - Only `A_greater_than_B` and `A_less_than_B` are used.

## Test plan
All scenarios use `WIDTH`=4, `PERSIST`=3, `thr_hi`=10, `thr_lo`=4.
- **Reset:** hold `rst_n`=0 with samples toggling → all outputs 0, `state`=0.
- **Entry:** samples 11, 12, 15 on consecutive edges → `alarm`=1 and `rise_pulse` for one cycle after the third, `alarm_count`=1.
- **Equality breaks arming:** samples 11, 10, 11, 11 → no alarm, `state`=ARMING at end with `pcnt`=2.
- **Hysteresis exit:** from alarm, samples 5, 3, 2, 1 → still alarm after 5 (not < 4). After 3, 2, 1 `fall_pulse` fires and `state`=NORMAL.
- **Gaps and clear:** samples 11, gap with valid=0, 11, then valid 11 together with `clear`=1 → `state`=NORMAL, no `rise_pulse`, `alarm_count`=0.
- **Sticky and saturation:**
  - With `THRMON_STICKY_EN`, samples 0, 0, 0 in alarm → `alarm` stays 1.
  - With `CNT_W`=2, four alarm episodes → `alarm_count`=3.

Source files
------------

// File: rtl/thrmon_pkg.sv
// Shared types and constants for the threshold monitor alarm stage.
package thrmon_pkg;

    localparam int THRMON_PCNT_W = 4;

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_ARMING   = 2'd1,
        ST_ALARM    = 2'd2,
        ST_CLEARING = 2'd3
    } thrmon_state_t;

endpackage

// File: rtl/MagnitudeComparator.sv
// Purely combinational unsigned magnitude comparator producing gt/lt/eq flags.
module MagnitudeComparator #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             A_greater_than_B,
    output logic             A_less_than_B,
    output logic             A_equal_to_B
);

    assign A_greater_than_B = (A > B);
    assign A_less_than_B    = (A < B);
    assign A_equal_to_B     = (A == B);

endmodule

// File: rtl/threshold_monitor.sv
// Debounced high/low threshold alarm with hysteresis and a saturating entry counter.
// Build option: define THRMON_STICKY_EN to latch the alarm until clear or reset.
module threshold_monitor
    import thrmon_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int PERSIST = 3,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    input  logic [WIDTH-1:0] thr_hi,
    input  logic [WIDTH-1:0] thr_lo,
    input  logic             clear,
    output logic             alarm,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] alarm_count
);

    localparam logic [THRMON_PCNT_W-1:0] PERSIST_C = THRMON_PCNT_W'(PERSIST);

    thrmon_state_t              st, st_nxt;
    logic [THRMON_PCNT_W-1:0]   pcnt, pcnt_nxt, pcnt_inc;
    logic                       hi_gt, lo_lt, enter, leave;
    logic                       hi_lt_unused, hi_eq_unused, lo_gt_unused, lo_eq_unused;

    MagnitudeComparator #(.WIDTH(WIDTH)) u_cmp_hi (
        .A                (sample),
        .B                (thr_hi),
        .A_greater_than_B (hi_gt),
        .A_less_than_B    (hi_lt_unused),
        .A_equal_to_B     (hi_eq_unused)
    );

    MagnitudeComparator #(.WIDTH(WIDTH)) u_cmp_lo (
        .A                (sample),
        .B                (thr_lo),
        .A_greater_than_B (lo_gt_unused),
        .A_less_than_B    (lo_lt),
        .A_equal_to_B     (lo_eq_unused)
    );

    assign pcnt_inc = pcnt + 1'b1;

    // pcnt restarts at 0 whenever a settled state (NORMAL/ALARM) is reached
    always_comb begin
        st_nxt   = st;
        pcnt_nxt = pcnt;
        enter    = 1'b0;
        leave    = 1'b0;
        case (st)
            ST_NORMAL: begin
                if (hi_gt) begin
                    if (PERSIST_C == 1) begin
                        st_nxt   = ST_ALARM;
                        pcnt_nxt = '0;
                        enter    = 1'b1;
                    end else begin
                        st_nxt   = ST_ARMING;
                        pcnt_nxt = THRMON_PCNT_W'(1);
                    end
                end
            end
            ST_ARMING: begin
                if (hi_gt) begin
                    if (pcnt_inc == PERSIST_C) begin
                        st_nxt   = ST_ALARM;
                        pcnt_nxt = '0;
                        enter    = 1'b1;
                    end else begin
                        pcnt_nxt = pcnt_inc;
                    end
                end else begin
                    st_nxt   = ST_NORMAL;
                    pcnt_nxt = '0;
                end
            end
            ST_ALARM: begin
`ifndef THRMON_STICKY_EN
                if (lo_lt) begin
                    if (PERSIST_C == 1) begin
                        st_nxt   = ST_NORMAL;
                        pcnt_nxt = '0;
                        leave    = 1'b1;
                    end else begin
                        st_nxt   = ST_CLEARING;
                        pcnt_nxt = THRMON_PCNT_W'(1);
                    end
                end
`endif
            end
            default: begin
`ifdef THRMON_STICKY_EN
                st_nxt   = ST_ALARM;
                pcnt_nxt = '0;
`else
                if (lo_lt) begin
                    if (pcnt_inc == PERSIST_C) begin
                        st_nxt   = ST_NORMAL;
                        pcnt_nxt = '0;
                        leave    = 1'b1;
                    end else begin
                        pcnt_nxt = pcnt_inc;
                    end
                end else begin
                    st_nxt   = ST_ALARM;
                    pcnt_nxt = '0;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= ST_NORMAL;
            pcnt        <= '0;
            alarm       <= 1'b0;
            rise_pulse  <= 1'b0;
            fall_pulse  <= 1'b0;
            alarm_count <= '0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            if (clear) begin
                st          <= ST_NORMAL;
                pcnt        <= '0;
                alarm       <= 1'b0;
                alarm_count <= '0;
            end else if (sample_valid) begin
                st         <= st_nxt;
                pcnt       <= pcnt_nxt;
                alarm      <= (st_nxt == ST_ALARM) || (st_nxt == ST_CLEARING);
                rise_pulse <= enter;
`ifndef THRMON_STICKY_EN
                fall_pulse <= leave;
`endif
                if (enter && (alarm_count != {CNT_W{1'b1}}))
                    alarm_count <= alarm_count + 1'b1;
            end
        end
    end

    assign state = st;

endmodule

// File: tb/tb_threshold_monitor.sv
// Directed bench for threshold_monitor: vector table plus hand-written corner sequences.
module tb_threshold_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_valid = 1'b0;
    logic [3:0] sample = '0;
    logic [3:0] thr_hi = 4'd10;
    logic [3:0] thr_lo = 4'd4;
    logic       clear = 1'b0;
    logic       alarm, rise_pulse, fall_pulse;
    logic [1:0] state;
    logic [7:0] alarm_count;
    logic       alarm2, rise2, fall2;
    logic [1:0] state2;
    logic [1:0] count2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    threshold_monitor #(.WIDTH(4), .PERSIST(3), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .clear(clear),
        .alarm(alarm), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .state(state), .alarm_count(alarm_count)
    );

    threshold_monitor #(.WIDTH(4), .PERSIST(3), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .clear(clear),
        .alarm(alarm2), .rise_pulse(rise2), .fall_pulse(fall2),
        .state(state2), .alarm_count(count2)
    );

    typedef struct {
        logic       v;
        logic       c;
        logic [3:0] s;
        logic       a;
        logic       r;
        logic       f;
        logic [1:0] st;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic c, input logic [3:0] s);
        sample_valid = v;
        clear        = c;
        sample       = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int idx, input logic a, input logic r,
                             input logic f, input logic [1:0] st, input logic [7:0] cnt);
        check({tag, ".alarm"}, idx, 32'(alarm), 32'(a));
        check({tag, ".rise"},  idx, 32'(rise_pulse), 32'(r));
        check({tag, ".fall"},  idx, 32'(fall_pulse), 32'(f));
        check({tag, ".state"}, idx, 32'(state), 32'(st));
        check({tag, ".count"}, idx, 32'(alarm_count), 32'(cnt));
    endtask

    function automatic void add(logic v, logic c, logic [3:0] s, logic a, logic r,
                                logic f, logic [1:0] st, logic [7:0] cnt);
        vec_t e;
        e.v = v; e.c = c; e.s = s; e.a = a; e.r = r; e.f = f; e.st = st; e.cnt = cnt;
        tbl.push_back(e);
    endfunction

    initial begin
        // reset held with live samples: nothing may move
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 4'd15);
            check_all("reset", i, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

`ifdef THRMON_STICKY_EN
        add(1, 0, 11, 0, 0, 0, 1, 0);
        add(1, 0, 12, 0, 0, 0, 1, 0);
        add(1, 0, 15, 1, 1, 0, 2, 1);
        add(1, 0,  0, 1, 0, 0, 2, 1);
        add(1, 0,  0, 1, 0, 0, 2, 1);
        add(1, 0,  0, 1, 0, 0, 2, 1);
        add(1, 1,  0, 0, 0, 0, 0, 0);
`else
        // entry
        add(1, 0, 11, 0, 0, 0, 1, 0);
        add(1, 0, 12, 0, 0, 0, 1, 0);
        add(1, 0, 15, 1, 1, 0, 2, 1);
        add(1, 0, 15, 1, 0, 0, 2, 1);
        // hysteresis exit: 5 is not below 4
        add(1, 0,  5, 1, 0, 0, 2, 1);
        add(1, 0,  3, 1, 0, 0, 3, 1);
        add(1, 0,  2, 1, 0, 0, 3, 1);
        add(1, 0,  1, 0, 0, 1, 0, 1);
        add(1, 0,  0, 0, 0, 0, 0, 1);
        // equality breaks arming
        add(1, 0, 11, 0, 0, 0, 1, 1);
        add(1, 0, 10, 0, 0, 0, 0, 1);
        add(1, 0, 11, 0, 0, 0, 1, 1);
        add(1, 0, 11, 0, 0, 0, 1, 1);
        add(1, 0, 11, 1, 1, 0, 2, 2);
        // gap holds, clearing aborted back to alarm
        add(0, 0,  0, 1, 0, 0, 2, 2);
        add(1, 0,  2, 1, 0, 0, 3, 2);
        add(1, 0,  9, 1, 0, 0, 2, 2);
        // clear while alarmed: no fall pulse
        add(1, 1,  0, 0, 0, 0, 0, 0);
        // gap during arming, then clear beats the third sample
        add(1, 0, 11, 0, 0, 0, 1, 0);
        add(0, 0, 11, 0, 0, 0, 1, 0);
        add(1, 0, 11, 0, 0, 0, 1, 0);
        add(1, 1, 11, 0, 0, 0, 0, 0);
        add(1, 0,  4, 0, 0, 0, 0, 0);
`endif
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].c, tbl[i].s);
            check_all("tbl", i, tbl[i].a, tbl[i].r, tbl[i].f, tbl[i].st, tbl[i].cnt);
        end

`ifndef THRMON_STICKY_EN
        // consecutive episodes: main counter counts, 2-bit counter saturates at 3
        for (int ep = 1; ep <= 4; ep++) begin
            for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 4'd11);
            check("ep.rise", ep, 32'(rise_pulse), 32'd1);
            check("ep.count", ep, 32'(alarm_count), 32'(ep));
            check("ep.count_sat", ep, 32'(count2), 32'((ep > 3) ? 3 : ep));
            for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 4'd0);
            check("ep.fall", ep, 32'(fall_pulse), 32'd1);
            check("ep.state", ep, 32'(state), 32'd0);
        end

        // inverted thresholds; new thresholds apply from the next sample onward
        step(1'b1, 1'b1, 4'd0);
        thr_hi = 4'd2;
        thr_lo = 4'd12;
        step(1'b1, 1'b0, 4'd8);
        step(1'b1, 1'b0, 4'd8);
        step(1'b1, 1'b0, 4'd8);
        check_all("inv", 0, 1'b1, 1'b1, 1'b0, 2'd2, 8'd1);
        step(1'b1, 1'b0, 4'd8);
        step(1'b1, 1'b0, 4'd8);
        check_all("inv", 1, 1'b1, 1'b0, 1'b0, 2'd3, 8'd1);
        step(1'b1, 1'b0, 4'd8);
        check_all("inv", 2, 1'b0, 1'b0, 1'b1, 2'd0, 8'd1);
        thr_hi = 4'd10;
        thr_lo = 4'd4;
`endif

        // asynchronous reset mid-alarm clears without a clock edge
        step(1'b1, 1'b0, 4'd11);
        step(1'b1, 1'b0, 4'd11);
        step(1'b1, 1'b0, 4'd11);
        check("async.pre", 0, 32'(alarm), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async", 0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
        #3;
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
